// File: rtl/aibcr3aux_por_pkg.sv
// Shared types and default constants for the AUX power-on-reset sequencer.
// The state encoding is visible to software through CSR readback.
package aibcr3aux_por_pkg;

  typedef enum logic [2:0] {
    POR_HOLD = 3'd0,
    DEBOUNCE = 3'd1,
    ANLG_REL = 3'd2,
    DIG_REL  = 3'd3,
    READY    = 3'd4
  } por_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 10;
  localparam int DEB_CYC_DEF     = 256;
  localparam int ANLG_DLY_DEF    = 32;
  localparam int DIG_DLY_DEF     = 32;

endpackage

// File: rtl/aibcr3aux_sync_rst1.sv
// Multi-flop synchronizer whose flops preset to 1 under reset.
// Generic for any AUX async input that must read as asserted-high during reset.
module aibcr3aux_sync_rst1 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/aibcr3aux_por_seq.sv
// AUX POR sequencer: debounces the partner-die POR level, then releases analog
// reset, digital reset and finally the ready status, with programmable spacing.
module aibcr3aux_por_seq
  import aibcr3aux_por_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEB_CYC     = DEB_CYC_DEF,
  parameter int ANLG_DLY    = ANLG_DLY_DEF,
  parameter int DIG_DLY     = DIG_DLY_DEF
) (
  input  logic       osc_clk,
  input  logic       rstb,
  input  logic       i_dn_por,
  input  logic       i_seq_en,
  input  logic       i_sw_rstb,
  output logic       o_anlg_rstb,
  output logic       o_dig_rstb,
  output logic       o_por_ready,
  output logic [2:0] o_por_state,
  output logic       o_deb_fail
);

  localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] ANLG_TERM = CNT_W'(ANLG_DLY - 1);
  localparam logic [CNT_W-1:0] DIG_TERM  = CNT_W'(DIG_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic       por_s;
  logic       abort;

  por_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             anlg_q, anlg_d;
  logic             dig_q, dig_d;
  logic             ready_q, ready_d;
  logic             deb_fail_q, deb_fail_d;

  aibcr3aux_sync_rst1 #(
    .STAGES (SYNC_STAGES)
  ) u_dn_por_sync (
    .clk   (osc_clk),
    .rst_n (rstb),
    .d     (i_dn_por),
    .q     (por_s)
  );

  assign abort = por_s | ~i_seq_en | ~i_sw_rstb;

  // NOTE: every _d signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    deb_fail_d = deb_fail_q;

    unique0 case (state_q)
      POR_HOLD: begin
        cnt_d = '0;
        if (!abort) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (por_s) begin
          deb_fail_d = 1'b1;
          state_d    = POR_HOLD;
          cnt_d      = '0;
        end else if (abort) begin
          state_d = POR_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_TERM) begin
          state_d = ANLG_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ANLG_REL: begin
        if (abort) begin
          state_d = POR_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == ANLG_TERM) begin
          state_d = DIG_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DIG_REL: begin
        if (abort) begin
          state_d = POR_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DIG_TERM) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      READY: begin
        cnt_d = '0;
        if (abort) state_d = POR_HOLD;
      end
      default: begin
        state_d = POR_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode next-state so they switch on the same edge as the state.
    anlg_d  = (state_d == ANLG_REL) || (state_d == DIG_REL) || (state_d == READY);
    dig_d   = (state_d == DIG_REL) || (state_d == READY);
    ready_d = (state_d == READY);
  end

  always_ff @(posedge osc_clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= POR_HOLD;
      cnt_q      <= '0;
      anlg_q     <= 1'b0;
      dig_q      <= 1'b0;
      ready_q    <= 1'b0;
      deb_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      anlg_q     <= anlg_d;
      dig_q      <= dig_d;
      ready_q    <= ready_d;
      deb_fail_q <= deb_fail_d;
    end
  end

  assign o_anlg_rstb = anlg_q;
  assign o_dig_rstb  = dig_q;
  assign o_por_ready = ready_q;
  assign o_por_state = state_q;
  assign o_deb_fail  = deb_fail_q;

  a_release_order : assert property (@(posedge osc_clk) disable iff (!rstb)
    (!ready_q || dig_q) && (!dig_q || anlg_q));

endmodule

// File: tb/tb_aibcr3aux_por_seq.sv
// Self-checking bench for aibcr3aux_por_seq: directed scenarios plus randomized
// stimulus, all compared against an elapsed-time reference model.
module tb_aibcr3aux_por_seq;

  localparam int SYNC  = 2;
  localparam int DEB   = 8;
  localparam int ADLY  = 4;
  localparam int DDLY  = 3;
  localparam int TOTAL = DEB + ADLY + DDLY;

  logic       osc_clk = 1'b0;
  logic       rstb;
  logic       i_dn_por;
  logic       i_seq_en;
  logic       i_sw_rstb;
  logic       o_anlg_rstb;
  logic       o_dig_rstb;
  logic       o_por_ready;
  logic [2:0] o_por_state;
  logic       o_deb_fail;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: run = -1 while held, otherwise cycles since debounce began.
  int run;
  int m_fail;
  int m_sync[SYNC];

  int edge_no;
  int rise_a, rise_d, rise_r;

  aibcr3aux_por_seq #(
    .SYNC_STAGES (SYNC),
    .CNT_W       (10),
    .DEB_CYC     (DEB),
    .ANLG_DLY    (ADLY),
    .DIG_DLY     (DDLY)
  ) dut (
    .osc_clk     (osc_clk),
    .rstb        (rstb),
    .i_dn_por    (i_dn_por),
    .i_seq_en    (i_seq_en),
    .i_sw_rstb   (i_sw_rstb),
    .o_anlg_rstb (o_anlg_rstb),
    .o_dig_rstb  (o_dig_rstb),
    .o_por_ready (o_por_ready),
    .o_por_state (o_por_state),
    .o_deb_fail  (o_deb_fail)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run    = -1;
    m_fail = 0;
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1;
  endtask

  task automatic model_edge();
    int por_s;
    int abort;
    por_s = m_sync[SYNC-1];
    abort = (por_s != 0 || i_seq_en == 1'b0 || i_sw_rstb == 1'b0) ? 1 : 0;
    if (abort != 0) begin
      if (run >= 0 && run < DEB && por_s != 0) m_fail = 1;
      run = -1;
    end else if (run < 0) begin
      run = 0;
    end else if (run < TOTAL) begin
      run++;
    end
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = int'(i_dn_por);
  endtask

  function automatic int m_state();
    if (run < 0)           return 0;
    if (run < DEB)         return 1;
    if (run < DEB + ADLY)  return 2;
    if (run < TOTAL)       return 3;
    return 4;
  endfunction

  task automatic compare();
    check("state",    int'(o_por_state), m_state());
    check("anlg",     int'(o_anlg_rstb), (run >= DEB) ? 1 : 0);
    check("dig",      int'(o_dig_rstb),  (run >= DEB + ADLY) ? 1 : 0);
    check("ready",    int'(o_por_ready), (run >= TOTAL) ? 1 : 0);
    check("deb_fail", int'(o_deb_fail),  m_fail);
  endtask

  task automatic clear_marks();
    edge_no = 0;
    rise_a  = -1;
    rise_d  = -1;
    rise_r  = -1;
  endtask

  // Called at a falling edge: drive, clock once, check at the next falling edge.
  task automatic step(input logic dn, input logic en, input logic sw);
    i_dn_por  = dn;
    i_seq_en  = en;
    i_sw_rstb = sw;
    @(posedge osc_clk);
    model_edge();
    @(negedge osc_clk);
    edge_no++;
    if (o_anlg_rstb && rise_a < 0) rise_a = edge_no;
    if (o_dig_rstb  && rise_d < 0) rise_d = edge_no;
    if (o_por_ready && rise_r < 0) rise_r = edge_no;
    compare();
  endtask

  task automatic sync_reset();
    rstb = 1'b0;
    #1;
    model_reset();
    @(negedge osc_clk);
    rstb = 1'b1;
    clear_marks();
    compare();
  endtask

  // Reset asserted between clock edges; outputs must clear with no edge.
  task automatic async_reset(input string tag);
    #2 rstb = 1'b0;
    #1;
    check({tag, "_anlg"},  int'(o_anlg_rstb), 0);
    check({tag, "_dig"},   int'(o_dig_rstb),  0);
    check({tag, "_ready"}, int'(o_por_ready), 0);
    check({tag, "_state"}, int'(o_por_state), 0);
    model_reset();
    @(negedge osc_clk);
    @(negedge osc_clk);
    rstb = 1'b1;
    clear_marks();
    compare();
  endtask

  initial begin
    int p_dn;
    rstb      = 1'b0;
    i_dn_por  = 1'b1;
    i_seq_en  = 1'b1;
    i_sw_rstb = 1'b1;
    model_reset();
    clear_marks();
    repeat (3) @(negedge osc_clk);
    check("rst_anlg",  int'(o_anlg_rstb), 0);
    check("rst_dig",   int'(o_dig_rstb),  0);
    check("rst_ready", int'(o_por_ready), 0);
    check("rst_state", int'(o_por_state), 0);
    check("rst_fail",  int'(o_deb_fail),  0);

    // Clean release: dn_por drops before edge 1.
    rstb = 1'b1;
    clear_marks();
    repeat (25) step(1'b0, 1'b1, 1'b1);
    check("t1_anlg_rise",  rise_a, SYNC + 1 + DEB);
    check("t1_dig_rise",   rise_d, SYNC + 1 + DEB + ADLY);
    check("t1_ready_rise", rise_r, SYNC + 1 + TOTAL);
    check("t1_state",      int'(o_por_state), 4);

    // POR returns while READY: all three drop together SYNC+1 edges later.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("t3_still_ready", int'(o_por_ready), 1);
    step(1'b1, 1'b1, 1'b1);
    check("t3_drop", int'({o_anlg_rstb, o_dig_rstb, o_por_ready}), 0);
    check("t3_fail", int'(o_deb_fail), 0);

    // One-cycle glitch while the debounce count is at 5.
    sync_reset();
    repeat (6) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (23) step(1'b0, 1'b1, 1'b1);
    check("t2_fail_sticky", int'(o_deb_fail), 1);
    check("t2_anlg_rise",   rise_a, 18);
    check("t2_ready_rise",  rise_r, 25);

    // Software reset pulse during DIG_REL.
    sync_reset();
    repeat (15) step(1'b0, 1'b1, 1'b1);
    check("t4_in_dig_rel", int'(o_por_state), 3);
    step(1'b0, 1'b1, 1'b0);
    check("t4_anlg_drop", int'(o_anlg_rstb), 0);
    check("t4_dig_drop",  int'(o_dig_rstb),  0);
    check("t4_fail",      int'(o_deb_fail),  0);
    repeat (19) step(1'b0, 1'b1, 1'b1);
    check("t4_ready_rise", rise_r, 32);

    // Sequencer disabled with POR already low, then enabled.
    sync_reset();
    repeat (20) step(1'b0, 1'b0, 1'b1);
    check("t5_held", int'(o_por_state), 0);
    clear_marks();
    repeat (18) step(1'b0, 1'b1, 1'b1);
    check("t5_ready_rise", rise_r, 1 + TOTAL);

    // Asynchronous reset in the middle of ANLG_REL.
    sync_reset();
    repeat (12) step(1'b0, 1'b1, 1'b1);
    check("t6_in_anlg_rel", int'(o_por_state), 2);
    async_reset("t6");

    // Randomized: segments with varying glitch density and occasional aborts/resets.
    p_dn = 0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) begin
        case ($urandom_range(0, 3))
          0:       p_dn = 0;
          1:       p_dn = 2;
          2:       p_dn = 10;
          default: p_dn = 60;
        endcase
      end
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rnd_async");
      end else begin
        step(($urandom_range(0, 99) < p_dn) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 2)    ? 1'b0 : 1'b1,
             ($urandom_range(0, 99) < 2)    ? 1'b0 : 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
